// File: rtl/nuc_pkg.sv
// Shared definitions for the NUC pixel pipeline: default widths, bad-pixel
// replacement FSM encoding and replacement-source selection.
package nuc_pkg;

    localparam int DATA_WIDTH_DEF = 14;
    localparam int MAX_LINE_DEF   = 640;
    localparam int ADDR_WIDTH_DEF = 10;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HOLD  = 2'd1,
        ST_FLUSH = 2'd2
    } bpr_state_e;

    typedef enum logic [2:0] {
        SRC_PASS  = 3'd0,
        SRC_AVG   = 3'd1,
        SRC_LEFT  = 3'd2,
        SRC_RIGHT = 3'd3,
        SRC_ABOVE = 3'd4,
        SRC_ZERO  = 3'd5
    } bpr_src_e;

    // Priority: horizontal average, single horizontal neighbour, pixel above, zero.
    function automatic bpr_src_e bpr_select(input logic bypass,
                                            input logic c_good,
                                            input logic l_ok,
                                            input logic r_ok,
                                            input logic above_ok);
        bpr_src_e src;
        if (bypass || c_good) begin
            src = SRC_PASS;
        end else if (l_ok && r_ok) begin
            src = SRC_AVG;
        end else if (l_ok) begin
            src = SRC_LEFT;
        end else if (r_ok) begin
            src = SRC_RIGHT;
        end else if (above_ok) begin
            src = SRC_ABOVE;
        end else begin
            src = SRC_ZERO;
        end
        return src;
    endfunction

endpackage

// File: rtl/nuc_bpr_linebuf.sv
// Previous-line pixel store: simple dual-port RAM, one write and one
// registered read per clock, read-before-write on address collision.
module nuc_bpr_linebuf
    import nuc_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int MAX_LINE   = MAX_LINE_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    logic [DATA_WIDTH-1:0] mem_q [0:MAX_LINE-1];
    logic [DATA_WIDTH-1:0] rd_data_q;

    // Write port.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Read port; sees the old contents when the same address is written.
    always_ff @(posedge clk) begin
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/nuc_bpr.sv
// Bad-pixel replacement: a 3-pixel horizontal window with a previous-line
// fallback, emitting one output pixel per accepted sample (plus a line flush).
module nuc_bpr
    import nuc_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int MAX_LINE   = MAX_LINE_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  sresetn,
    input  logic                  bypass,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_good,
    input  logic                  s_sol,
    input  logic                  s_eol,
    input  logic                  s_sof,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_sol,
    output logic                  m_eol,
    output logic                  m_repl
);

    // The column counter must be able to hold MAX_LINE itself (saturation value).
    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] COL_MAX  = CW'(MAX_LINE);
    localparam logic [CW-1:0] COL_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] COL_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH:0] SUM_ONE = {{DATA_WIDTH{1'b0}}, 1'b1};

    bpr_state_e            state_q, state_d;
    logic [DATA_WIDTH-1:0] c_data_q, c_data_d;
    logic                  c_good_q, c_good_d;
    logic                  c_sol_q, c_sol_d;
    logic [DATA_WIDTH-1:0] l_data_q, l_data_d;
    logic                  l_good_q, l_good_d;
    logic                  l_pres_q, l_pres_d;
    logic [CW-1:0]         col_q, col_d;
    logic                  plv_q, plv_d;

    logic                  m_valid_q, m_valid_d;
    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic                  m_sol_q, m_sol_d;
    logic                  m_eol_q, m_eol_d;
    logic                  m_repl_q, m_repl_d;

    logic                  ready_s;
    logic                  accept_s;
    logic                  emit_s;
    logic                  eol_s;
    logic                  r_pres_s;
    logic [CW-1:0]         emit_col_s;
    logic                  col_ok_s;
    logic [CW-1:0]         nxt_col_s;
    logic [DATA_WIDTH:0]   sum_s;
    logic [DATA_WIDTH-1:0] avg_s;
    logic [DATA_WIDTH-1:0] out_data_s;
    logic                  out_repl_s;
    bpr_src_e              src_s;
    logic [DATA_WIDTH-1:0] rd_data_s;
    logic                  rd_en_s;
    logic                  wr_en_s;

    assign ready_s  = (state_q != ST_FLUSH);
    assign accept_s = s_valid & ready_s;

    // Window FSM: decides when C is emitted and how the window shifts.
    always_comb begin
        state_d  = state_q;
        c_data_d = c_data_q;
        c_good_d = c_good_q;
        c_sol_d  = c_sol_q;
        l_data_d = l_data_q;
        l_good_d = l_good_q;
        l_pres_d = l_pres_q;
        emit_s   = 1'b0;
        eol_s    = 1'b0;
        r_pres_s = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (accept_s) begin
                    c_data_d = s_data;
                    c_good_d = s_good;
                    c_sol_d  = s_sol;
                    l_pres_d = 1'b0;
                    state_d  = (s_sol & s_eol) ? ST_FLUSH : ST_HOLD;
                end else begin
                    state_d  = ST_EMPTY;
                end
            end
            ST_HOLD: begin
                if (accept_s && s_sol) begin
                    // Previous line never saw its eol: close it, then start afresh.
                    emit_s   = 1'b1;
                    eol_s    = 1'b1;
                    c_data_d = s_data;
                    c_good_d = s_good;
                    c_sol_d  = 1'b1;
                    l_pres_d = 1'b0;
                    state_d  = s_eol ? ST_FLUSH : ST_HOLD;
                end else if (accept_s) begin
                    emit_s   = 1'b1;
                    r_pres_s = 1'b1;
                    l_data_d = c_data_q;
                    l_good_d = c_good_q;
                    l_pres_d = 1'b1;
                    c_data_d = s_data;
                    c_good_d = s_good;
                    c_sol_d  = 1'b0;
                    state_d  = s_eol ? ST_FLUSH : ST_HOLD;
                end else begin
                    state_d  = ST_HOLD;
                end
            end
            ST_FLUSH: begin
                emit_s  = 1'b1;
                eol_s   = 1'b1;
                state_d = ST_EMPTY;
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    // Replacement datapath, column tracking and registered output next-state.
    always_comb begin
        emit_col_s = c_sol_q ? COL_ZERO : col_q;
        col_ok_s   = (emit_col_s < COL_MAX);
        sum_s      = {1'b0, l_data_q} + {1'b0, s_data} + SUM_ONE;
        avg_s      = sum_s[DATA_WIDTH:1];
        src_s      = bpr_select(bypass, c_good_q,
                                l_pres_q & l_good_q,
                                r_pres_s & s_good,
                                plv_q & col_ok_s);
        case (src_s)
            SRC_PASS:  out_data_s = c_data_q;
            SRC_AVG:   out_data_s = avg_s;
            SRC_LEFT:  out_data_s = l_data_q;
            SRC_RIGHT: out_data_s = s_data;
            SRC_ABOVE: out_data_s = rd_data_s;
            SRC_ZERO:  out_data_s = {DATA_WIDTH{1'b0}};
            default:   out_data_s = c_data_q;
        endcase
        out_repl_s = (src_s != SRC_PASS) && (src_s != SRC_ZERO);

        if (emit_s) begin
            col_d = col_ok_s ? (emit_col_s + COL_ONE) : COL_MAX;
        end else begin
            col_d = col_q;
        end

        // A new frame overrides the eol that may close the previous line.
        if (accept_s && s_sof && s_sol) begin
            plv_d = 1'b0;
        end else if (emit_s && eol_s) begin
            plv_d = 1'b1;
        end else begin
            plv_d = plv_q;
        end

        // Prefetch the column the next-cycle C will be emitted at.
        nxt_col_s = c_sol_d ? COL_ZERO : col_d;
        rd_en_s   = (nxt_col_s < COL_MAX);
        wr_en_s   = emit_s & col_ok_s;

        m_valid_d = emit_s;
        m_data_d  = emit_s ? out_data_s : {DATA_WIDTH{1'b0}};
        m_sol_d   = emit_s & c_sol_q;
        m_eol_d   = emit_s & eol_s;
        m_repl_d  = emit_s & out_repl_s;
    end

    // State, window and output registers.
    always_ff @(posedge clk) begin
        if (!sresetn) begin
            state_q   <= ST_EMPTY;
            c_data_q  <= {DATA_WIDTH{1'b0}};
            c_good_q  <= 1'b0;
            c_sol_q   <= 1'b0;
            l_data_q  <= {DATA_WIDTH{1'b0}};
            l_good_q  <= 1'b0;
            l_pres_q  <= 1'b0;
            col_q     <= COL_ZERO;
            plv_q     <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= {DATA_WIDTH{1'b0}};
            m_sol_q   <= 1'b0;
            m_eol_q   <= 1'b0;
            m_repl_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            c_data_q  <= c_data_d;
            c_good_q  <= c_good_d;
            c_sol_q   <= c_sol_d;
            l_data_q  <= l_data_d;
            l_good_q  <= l_good_d;
            l_pres_q  <= l_pres_d;
            col_q     <= col_d;
            plv_q     <= plv_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_sol_q   <= m_sol_d;
            m_eol_q   <= m_eol_d;
            m_repl_q  <= m_repl_d;
        end
    end

    nuc_bpr_linebuf #(
        .DATA_WIDTH (DATA_WIDTH),
        .MAX_LINE   (MAX_LINE),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_linebuf (
        .clk       (clk),
        .wr_en_i   (wr_en_s),
        .wr_addr_i (emit_col_s[ADDR_WIDTH-1:0]),
        .wr_data_i (out_data_s),
        .rd_en_i   (rd_en_s),
        .rd_addr_i (nxt_col_s[ADDR_WIDTH-1:0]),
        .rd_data_o (rd_data_s)
    );

    assign s_ready = ready_s;
    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_sol   = m_sol_q;
    assign m_eol   = m_eol_q;
    assign m_repl  = m_repl_q;

endmodule

// File: tb/tb_nuc_bpr.sv
// Bench for nuc_bpr: directed lines plus random lines checked against a
// line-level reference model of the replacement rules.
module tb_nuc_bpr;

    localparam int DW = 14;
    localparam int ML = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          sresetn = 1'b0;
    logic          bypass = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data = '0;
    logic          s_good = 1'b0;
    logic          s_sol = 1'b0;
    logic          s_eol = 1'b0;
    logic          s_sof = 1'b0;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_sol;
    logic          m_eol;
    logic          m_repl;

    nuc_bpr #(.DATA_WIDTH(DW), .MAX_LINE(ML), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .sresetn(sresetn), .bypass(bypass),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_good(s_good),
        .s_sol(s_sol), .s_eol(s_eol), .s_sof(s_sof),
        .m_valid(m_valid), .m_data(m_data), .m_sol(m_sol), .m_eol(m_eol), .m_repl(m_repl)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int eol_acc = -100;

    // Reference model state.
    int  pv_mem [ML];
    bit  pv = 1'b0;
    int  exp_q [$];
    int  ln_d [64];
    bit  ln_g [64];
    int  got_d [64];
    int  got_r [64];
    int  got_n = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Output monitor: compares every emitted pixel and the eol handshake timing.
    always @(negedge clk) begin
        int e;
        if (sresetn) begin
            if (cyc == eol_acc + 1) check("ready_low_after_eol", int'(s_ready), 0);
            if (cyc == eol_acc + 2) check("ready_back_after_flush", int'(s_ready), 1);
            if (s_valid && s_ready && s_eol) eol_acc = cyc;
            if (m_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_m_valid", int'(m_valid), 0);
                end else begin
                    e = exp_q.pop_front();
                    check("m_data", int'(m_data), e & 32'h3FFF);
                    check("m_sol", int'(m_sol), (e >> 16) & 32'h1);
                    check("m_eol", int'(m_eol), (e >> 17) & 32'h1);
                    check("m_repl", int'(m_repl), (e >> 18) & 32'h1);
                    if (m_eol) check("eol_latency", cyc - eol_acc, 2);
                end
                if (m_sol) got_n = 0;
                if (got_n < 64) begin
                    got_d[got_n] = int'(m_data);
                    got_r[got_n] = int'(m_repl);
                    got_n++;
                end
            end
        end
    end

    task automatic setpx(input int i, input int d, input bit g);
        ln_d[i] = d;
        ln_g[i] = g;
    endtask

    // Whole-line model: each bad pixel looks at its original neighbours,
    // then at the same column of the previous output line of this frame.
    task automatic model_line(input int n, input bit sof, input bit byp);
        int o [64];
        int r;
        bit lok, rok;
        if (sof) pv = 1'b0;
        for (int i = 0; i < n; i++) begin
            lok = (i > 0) && ln_g[i-1];
            rok = (i < n - 1) && ln_g[i+1];
            r = 1;
            if (byp || ln_g[i]) begin
                o[i] = ln_d[i]; r = 0;
            end else if (lok && rok) begin
                o[i] = (ln_d[i-1] + ln_d[i+1] + 1) / 2;
            end else if (lok) begin
                o[i] = ln_d[i-1];
            end else if (rok) begin
                o[i] = ln_d[i+1];
            end else if (pv && i < ML) begin
                o[i] = pv_mem[i];
            end else begin
                o[i] = 0; r = 0;
            end
            exp_q.push_back(o[i] | ((i == 0) ? (1 << 16) : 0)
                                 | ((i == n - 1) ? (1 << 17) : 0) | (r << 18));
        end
        for (int i = 0; i < n && i < ML; i++) pv_mem[i] = o[i];
        pv = 1'b1;
    endtask

    task automatic drive_px(input int d, input bit g, input bit sol, input bit eol, input bit sof);
        int n;
        repeat ($urandom_range(0, 2)) begin
            @(negedge clk);
            s_valid = 1'b0;
        end
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = d[DW-1:0];
        s_good  = g;
        s_sol   = sol;
        s_eol   = eol;
        s_sof   = sof;
        n = 0;
        while (!s_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) check("accept_timeout", 0, 1);
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        s_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_line(input int n, input bit sof, input bit byp);
        @(negedge clk);
        bypass = byp;
        model_line(n, sof, byp);
        for (int i = 0; i < n; i++)
            drive_px(ln_d[i], ln_g[i], i == 0, i == n - 1, sof && (i == 0));
        idle(4);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int  n;
        bit  sof, byp;

        repeat (3) @(negedge clk);
        sresetn = 1'b1;
        @(negedge clk);
        check("rst_m_valid", int'(m_valid), 0);
        check("rst_m_data", int'(m_data), 0);
        check("rst_m_flags", int'({m_sol, m_eol, m_repl}), 0);
        check("rst_s_ready", int'(s_ready), 1);

        // Good line passes through untouched.
        for (int i = 0; i < 4; i++) setpx(i, 100 + i, 1'b1);
        send_line(4, 1'b1, 1'b0);
        check("good_cnt", got_n, 4);
        check("good_first", got_d[0], 100);
        check("good_last", got_d[3], 103);
        check("good_repl", got_r[1], 0);

        // Bad middle pixel averaged from both neighbours.
        setpx(0, 200, 1'b1); setpx(1, 0, 1'b0); setpx(2, 301, 1'b1);
        send_line(3, 1'b0, 1'b0);
        check("mid_avg", got_d[1], 251);
        check("mid_repl", got_r[1], 1);

        // Bad edge pixels take their single neighbour.
        setpx(0, 0, 1'b0); setpx(1, 50, 1'b1); setpx(2, 60, 1'b1); setpx(3, 0, 1'b0);
        send_line(4, 1'b0, 1'b0);
        check("edge_first", got_d[0], 50);
        check("edge_last", got_d[3], 60);
        check("edge_repl", got_r[0] + got_r[3], 2);

        // Vertical fallback inside a frame, none on a frame's first line.
        setpx(0, 10, 1'b1); setpx(1, 20, 1'b1); setpx(2, 30, 1'b1);
        send_line(3, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) setpx(i, 0, 1'b0);
        send_line(3, 1'b0, 1'b0);
        check("vert_0", got_d[0], 10);
        check("vert_1", got_d[1], 20);
        check("vert_2", got_d[2], 30);
        check("vert_repl", got_r[1], 1);
        send_line(3, 1'b1, 1'b0);
        check("sof_zero", got_d[1], 0);
        check("sof_repl", got_r[1], 0);

        // Bypass passes the bad pixel raw.
        setpx(0, 500, 1'b1); setpx(1, 0, 1'b0); setpx(2, 600, 1'b1);
        send_line(3, 1'b0, 1'b1);
        check("byp_data", got_d[1], 0);
        check("byp_repl", got_r[1], 0);

        // Reset while one pixel is held in the window.
        drive_px(7, 1'b1, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        s_valid = 1'b0;
        sresetn = 1'b0;
        exp_q.delete();
        pv = 1'b0;
        repeat (2) @(negedge clk);
        sresetn = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("no_valid_after_rst", int'(m_valid), 0);
        end
        for (int i = 0; i < 3; i++) setpx(i, 0, 1'b0);
        got_n = 99;
        send_line(3, 1'b0, 1'b0);
        check("rst_line_cnt", got_n, 3);
        check("rst_line_data", got_d[0] + got_d[1] + got_d[2], 0);
        check("rst_line_repl", got_r[0] + got_r[1] + got_r[2], 0);

        // Fill every buffer column, then random traffic including over-long lines.
        for (int i = 0; i < ML + 2; i++) setpx(i, $urandom_range(0, 16383), 1'b1);
        send_line(ML + 2, 1'b0, 1'b0);
        for (int k = 0; k < 40; k++) begin
            n   = $urandom_range(1, ML + 4);
            sof = ($urandom_range(0, 3) == 0);
            byp = ($urandom_range(0, 4) == 0);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 9) < 7) setpx(i, $urandom_range(0, 16383), 1'b1);
                else setpx(i, 0, 1'b0);
            end
            send_line(n, sof, byp);
        end

        idle(5);
        check("exp_drain", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
